// File: rtl/cpu_bus_pkg.sv
// Shared CPU memory-bus definitions for the byte-wide fetch and store paths.
// Byte order of word stores is selected by CPU_SER_LOW_FIRST_EN (undefined: high byte first).
// Widths here are fixed; WORD_W is always two bus bytes.
package cpu_bus_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 2 * BYTE_W;
  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } ser_state_t;

  // Returns the byte of a word that goes out first (second=0) or second (second=1).
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input logic              second);
`ifdef CPU_SER_LOW_FIRST_EN
    pick_byte = second ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
`else
    pick_byte = second ? word[BYTE_W-1:0] : word[WORD_W-1:BYTE_W];
`endif
  endfunction

endpackage

// File: rtl/cpu_word_serializer.sv
// Splits a 16-bit CPU store into two byte writes at consecutive addresses.
// Latency: first byte on the bus one cycle after acceptance; done 3 cycles after acceptance with no wait states.
// Backpressure: in_ready only in IDLE; mem_ready=0 holds the current byte indefinitely.
// Byte order: high byte first unless CPU_SER_LOW_FIRST_EN is defined.
module cpu_word_serializer
  import cpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      addr_q     <= '0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q   <= mem_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a handshake advances it.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    addr_d     = addr_q;
    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
    mem_wr_d   = mem_wr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Capture the word so later input changes cannot disturb this transfer.
          word_d     = in_word;
          addr_d     = in_addr;
          mem_data_d = pick_byte(in_word, 1'b0);
          mem_addr_d = in_addr;
          mem_wr_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = BYTE0;
        end
      end
      BYTE0: begin
        if (mem_ready) begin
          // Address wraps naturally at the top of the 13-bit space.
          mem_data_d = pick_byte(word_q, 1'b1);
          mem_addr_d = addr_q + ADDR_W'(1);
          state_d    = BYTE1;
        end
      end
      BYTE1: begin
        if (mem_ready) begin
          // Data and address keep their last values; only the strobe drops.
          mem_wr_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign mem_data = mem_data_q;
  assign mem_addr = mem_addr_q;
  assign mem_wr   = mem_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cpu_word_serializer.sv
// Bench for cpu_word_serializer: directed scenarios plus random words and wait states.
// A queue of expected bus writes is filled on each input handshake and drained on each accepted byte.
// Byte order follows CPU_SER_LOW_FIRST_EN, same as the design build.
module tb_cpu_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_word;
  logic [12:0] in_addr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mem_data;
  logic [12:0] mem_addr;
  logic        mem_wr;
  logic        mem_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  cpu_word_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    bit          last;
  } wr_t;

  wr_t expq[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  done_cnt    = 0;
  bit  last_hs     = 1'b0;

  // Reference byte order: plain arithmetic on the word value.
  function automatic logic [7:0] exp_byte(input logic [15:0] w, input bit second);
    int hi;
    int lo;
    hi = int'(w) / 256;
    lo = int'(w) % 256;
`ifdef CPU_SER_LOW_FIRST_EN
    return second ? 8'(hi) : 8'(lo);
`else
    return second ? 8'(lo) : 8'(hi);
`endif
  endfunction

  function automatic logic [12:0] next_addr(input logic [12:0] a);
    return 13'((int'(a) + 1) % 8192);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs/outputs, advance, then check post-edge outputs.
  task automatic cycle();
    bit  hs;
    bit  bw;
    bit  was_rst;
    bit  exp_done;
    wr_t w;
    hs       = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
    bw       = (mem_wr === 1'b1) && (mem_ready === 1'b1) && (rst === 1'b0);
    was_rst  = (rst === 1'b1);
    exp_done = 1'b0;
    if (bw) begin
      chk("write_was_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        w = expq.pop_front();
        chk("wr_data", 32'(mem_data), 32'(w.data));
        chk("wr_addr", 32'(mem_addr), 32'(w.addr));
        exp_done = w.last;
      end
    end
    if (hs) begin
      w.addr = in_addr;
      w.data = exp_byte(in_word, 1'b0);
      w.last = 1'b0;
      expq.push_back(w);
      w.addr = next_addr(in_addr);
      w.data = exp_byte(in_word, 1'b1);
      w.last = 1'b1;
      expq.push_back(w);
    end
    last_hs = hs;
    @(posedge clk);
    #1;
    if (was_rst) expq.delete();
    if (done === 1'b1) done_cnt++;
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(expq.size() != 0));
    chk("mem_wr", 32'(mem_wr), 32'(expq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(expq.size() == 0));
    if (expq.size() != 0) begin
      chk("bus_data", 32'(mem_data), 32'(expq[0].data));
      chk("bus_addr", 32'(mem_addr), 32'(expq[0].addr));
    end
  endtask

  initial begin
    int d0;
    int budget;
    logic [15:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    in_word   = '0;
    in_addr   = '0;

    // Reset for two cycles.
    cycle();
    cycle();
    chk("rst_mem_data", 32'(mem_data), 32'h00);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    cycle();

    // Single word, no wait states.
    in_word = 16'hA55A; in_addr = 13'h0100; in_valid = 1'b1; mem_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t2_b0_data", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b0)));
    chk("t2_b0_addr", 32'(mem_addr), 32'h0100);
    cycle();
    chk("t2_b1_data", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b1)));
    chk("t2_b1_addr", 32'(mem_addr), 32'h0101);
    cycle();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_data_kept", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b1)));
    cycle();
    chk("t2_done_one_cycle", 32'(done), 32'd0);

    // Wait states in both bytes; in_valid pulses during the transfer are ignored.
    d0 = done_cnt;
    in_word = 16'hA55A; in_addr = 13'h0040; in_valid = 1'b1; mem_ready = 1'b0;
    cycle();
    chk("t3_b0_first", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b0)));
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      in_word  = 16'hFFFF;
      in_addr  = 13'h1234;
      cycle();
      chk("t3_b0_hold", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b0)));
    end
    in_valid = 1'b0;
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = (i == 0);
      cycle();
      chk("t3_b1_hold", 32'(mem_data), 32'(exp_byte(16'hA55A, 1'b1)));
      chk("t3_b1_addr", 32'(mem_addr), 32'h0041);
    end
    in_valid = 1'b0;
    mem_ready = 1'b1;
    cycle();
    cycle();
    chk("t3_one_done", 32'(done_cnt - d0), 32'd1);

    // Address wrap at the top of memory.
    in_word = 16'h1234; in_addr = 13'h1FFF; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t4_addr0", 32'(mem_addr), 32'h1FFF);
    cycle();
    chk("t4_addr1", 32'(mem_addr), 32'h0000);
    chk("t4_data1", 32'(mem_data), 32'(exp_byte(16'h1234, 1'b1)));
    cycle();
    cycle();

    // Reset while stalled in the first byte.
    d0 = done_cnt;
    in_word = 16'hBEEF; in_addr = 13'h0AAA; in_valid = 1'b1; mem_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_wr", 32'(mem_wr), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_data", 32'(mem_data), 32'h00);
    mem_ready = 1'b1;
    cycle();
    cycle();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset and in_valid together: the word is dropped.
    rst = 1'b1; in_valid = 1'b1; in_word = 16'h7777;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("t5b_not_accepted", 32'(busy), 32'd0);
    cycle();

    // Back-to-back words with in_valid held.
    d0 = done_cnt;
    in_word = 16'h1111; in_addr = 13'h0200; in_valid = 1'b1; mem_ready = 1'b1;
    cycle();
    in_word = 16'h2222; in_addr = 13'h0300;
    cycle();
    chk("t6_w0_b1", 32'(mem_data), 32'(exp_byte(16'h1111, 1'b1)));
    cycle();
    chk("t6_gap_wr", 32'(mem_wr), 32'd0);
    cycle();
    in_valid = 1'b0;
    chk("t6_w1_b0", 32'(mem_data), 32'(exp_byte(16'h2222, 1'b0)));
    chk("t6_w1_addr", 32'(mem_addr), 32'h0300);
    cycle();
    chk("t6_w1_b1", 32'(mem_data), 32'(exp_byte(16'h2222, 1'b1)));
    cycle();
    cycle();
    chk("t6_two_done", 32'(done_cnt - d0), 32'd2);

    // Random words, addresses and wait states.
    d0 = done_cnt;
    for (int n = 0; n < 30; n++) begin
      w        = 16'($urandom);
      in_word  = w;
      in_addr  = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom);
      in_valid = 1'b1;
      budget   = 0;
      while ((in_valid || expq.size() != 0) && budget < 200) begin
        mem_ready = ($urandom_range(0, 2) != 0);
        cycle();
        if (last_hs) begin
          in_valid = 1'b0;
          in_word  = 16'($urandom);
          in_addr  = 13'($urandom);
        end
        budget++;
      end
      chk("rand_drained", 32'(expq.size() + int'(in_valid)), 32'd0);
      for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
    end
    chk("rand_done_count", 32'(done_cnt - d0), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
